seg7_time_display: RTL and testbench

- Consumer of the time counter's BCD digit outputs (min_ones, min_tens, hour_ones, hour_tens).
- Drives a 4-digit multiplexed, common-anode seven-segment display on the board.
- Time-multiplexes the digits with a programmable refresh rate and anti-ghosting dead time.
- Latches a coherent snapshot of all four digits once per frame, so a carry ripple never shows a torn time.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/bcd_to_seg7.sv | 28 ++
 rtl/seg7_time_display.sv | 170 +++++++++++++++++
 tb/tb_seg7_time_display.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment time display.
//   digit_idx_t   - digit slot currently being driven (DIG0 = rightmost)
//   time_digits_t - one coherent HH:MM snapshot in BCD
//   SEG_*         - active-high segment patterns, bit order {g,f,e,d,c,b,a}
package seg7_pkg;

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_idx_t;

    typedef struct packed {
        logic [3:0] hour_tens;
        logic [3:0] hour_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
    } time_digits_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-high seven-segment pattern.
//   bcd     in  4  BCD digit; codes A-F are shown as a dash
//   pattern out 7  segments {g,f,e,d,c,b,a}, 1 = lit
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_time_display.sv
// seg7_time_display: 4-digit multiplexed seven-segment driver for an HH:MM
// BCD time. Each digit gets a slot of REFRESH_DIV cycles whose first
// BLANK_CYCLES cycles keep all anodes off (anti-ghosting). All four digits
// are snapshotted at the end of every frame so a carry ripple in the source
// counter can never be shown half-applied.
//   clk        in  1  system clock
//   reset      in  1  synchronous, active-high
//   min_ones   in  4  BCD minutes ones   (an[0], rightmost)
//   min_tens   in  4  BCD minutes tens   (an[1])
//   hour_ones  in  4  BCD hours ones     (an[2])
//   hour_tens  in  4  BCD hours tens     (an[3]); a zero here is suppressed
//   blank      in  1  forces all anodes off while high
//   seg        out 7  registered segments {g,f,e,d,c,b,a}
//   dp         out 1  registered decimal point / colon
//   an         out 4  registered digit enables
// Optional feature macro: COLON_BLINK_EN - blinking colon on the DIG2 dp,
// toggling every BLINK_FRAMES frames. Without it dp stays off.
module seg7_time_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int BLINK_FRAMES   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] hour_ones,
    input  logic [3:0] hour_tens,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]    AN_OFF   = AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
    localparam logic          DP_OFF   = SEG_ACTIVE_LOW;

    logic [CW-1:0] refresh_cnt;
    digit_idx_t    idx;
    digit_idx_t    idx_next;
    time_digits_t  snapshot;

    logic          slot_end;
    logic          frame_end;
    logic          in_dead;
    logic          suppress;
    logic          lit;
    logic          dp_on;
    logic [3:0]    cur_digit;
    logic [6:0]    cur_pattern;
    logic [3:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign slot_end  = (refresh_cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == DIG3);

    // Dead time at the start of every slot; a zero-length window needs no compare.
    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (refresh_cnt < CW'(BLANK_CYCLES));
        end
    endgenerate

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            idx         <= DIG0;
            snapshot    <= '0;
        end else begin
            refresh_cnt <= slot_end ? '0 : refresh_cnt + CW'(1);
            idx         <= idx_next;
            // Loaded on the last cycle of DIG3 so the whole next frame is coherent.
            if (frame_end) begin
                snapshot <= '{hour_tens: hour_tens, hour_ones: hour_ones,
                              min_tens:  min_tens,  min_ones:  min_ones};
            end
        end
    end

    // ---- next-state: slot sequencer wraps DIG3 -> DIG0 naturally in 2 bits ----
    always_comb begin
        idx_next = idx;
        if (slot_end) idx_next = digit_idx_t'(idx + 2'd1);
    end

    // ---- digit select and decode ----
    always_comb begin
        cur_digit = snapshot.min_ones;
        case (idx)
            DIG0:    cur_digit = snapshot.min_ones;
            DIG1:    cur_digit = snapshot.min_tens;
            DIG2:    cur_digit = snapshot.hour_ones;
            DIG3:    cur_digit = snapshot.hour_tens;
            default: cur_digit = snapshot.min_ones;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd     (cur_digit),
        .pattern (cur_pattern)
    );

    assign suppress = (idx == DIG3) && (snapshot.hour_tens == 4'd0);
    assign lit      = !blank && !in_dead && !suppress;

`ifdef COLON_BLINK_EN
    localparam int            FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // The colon sits on the hours-ones digit.
    assign dp_on = lit && (idx == DIG2) && blink_q;
`else
    // BLINK_FRAMES has no function without the colon feature.
    logic [31:0] unused_blink_frames;
    assign unused_blink_frames = 32'(BLINK_FRAMES);
    assign dp_on = 1'b0;
`endif

    // ---- output decode (pre-register) ----
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (lit) begin
            an_next  = AN_ACTIVE_LOW ? ~(4'b0001 << idx) : (4'b0001 << idx);
            seg_next = SEG_ACTIVE_LOW ? ~cur_pattern : cur_pattern;
        end
        dp_next = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg7_time_display.sv
// tb_seg7_time_display: self-checking bench for seg7_time_display with
// REFRESH_DIV=8, BLANK_CYCLES=2, active-low segments and anodes,
// BLINK_FRAMES=2. A cycle-indexed reference model checks every output on
// every clock; directed checkpoints pin down the documented scenarios, then
// a randomized phase exercises inputs, blank and mid-frame resets.
module tb_seg7_time_display;

    localparam int DIV   = 8;
    localparam int BLNK  = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] min_ones = '0, min_tens = '0, hour_ones = '0, hour_tens = '0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;   // cycles since reset release, as seen by the model

    seg7_time_display #(
        .REFRESH_DIV    (DIV),
        .BLANK_CYCLES   (BLNK),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1),
        .BLINK_FRAMES   (BF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .min_ones  (min_ones),
        .min_tens  (min_tens),
        .hour_ones (hour_ones),
        .hour_tens (hour_tens),
        .blank     (blank),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Active-high digit patterns straight from the decode table.
    function automatic logic [6:0] pat(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d <= 4'd9) ? tbl[d] : 7'h40;
    endfunction

    // Reference model: position in the frame follows from the cycle count;
    // the shown digits are whatever the inputs were at the last frame end.
    logic [3:0] snap [4];
    always @(posedge clk) begin
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         pos, slot, off, frame;
        logic       on;
        if (reset) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            k = 0;
            for (int i = 0; i < 4; i++) snap[i] = 4'd0;
        end else begin
            pos   = k % FRAME;
            slot  = pos / DIV;
            off   = pos % DIV;
            frame = k / FRAME;
            on    = !blank && (off >= BLNK) && !(slot == 3 && snap[3] == 4'd0);
            e_an  = on ? ~(4'b0001 << slot) : 4'hF;
            e_seg = on ? ~pat(snap[slot]) : 7'h7F;
            e_dp  = 1'b1;
`ifdef COLON_BLINK_EN
            if (on && slot == 2 && ((frame / BF) % 2) == 1) e_dp = 1'b0;
`endif
            if (pos == FRAME - 1) begin
                snap[0] = min_ones; snap[1] = min_tens;
                snap[2] = hour_ones; snap[3] = hour_tens;
            end
            k++;
        end
        #1;
        chk("mdl_an", 32'(an), 32'(e_an));
        chk("mdl_seg", 32'(seg), 32'(e_seg));
        chk("mdl_dp", 32'(dp), 32'(e_dp));
    end

    // Return at the negedge following model edge t (outputs reflect that edge).
    task automatic at_edge(input int t);
        int budget;
        budget = 2000;
        while (k != t + 1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("timeout", 32'(k), 32'(t + 1));
    endtask

    task automatic set_time(input logic [3:0] ht, input logic [3:0] ho,
                            input logic [3:0] mt, input logic [3:0] mo);
        hour_tens = ht; hour_ones = ho; min_tens = mt; min_ones = mo;
    endtask

    initial begin
        // 1: reset state, then hold reset past a would-be terminal count
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'h0F);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        set_time(4'd1, 4'd2, 4'd3, 4'd4);
        repeat (7) @(negedge clk);
        reset = 1'b0;
        at_edge(1);  chk("dead_an", 32'(an), 32'h0F);
        at_edge(2);  chk("dig0_first", 32'(an), 32'hE);
        chk("zero_seg", 32'(seg), 32'h40);
        at_edge(26); chk("lead0_an", 32'(an), 32'hF);

        // 2: 12:34 visible in the second frame
        at_edge(33); chk("f1_dead", 32'(an), 32'hF);
        at_edge(34); chk("f1_d0_an", 32'(an), 32'hE);
        chk("f1_d0_seg", 32'(seg), 32'h19);
        at_edge(58); chk("f1_d3_an", 32'(an), 32'h7);
        chk("f1_d3_seg", 32'(seg), 32'h79);

        // 4: change to 23:59 during DIG1 of frame 2
        at_edge(72); set_time(4'd2, 4'd3, 4'd5, 4'd9);
        at_edge(82); chk("f2_d2_seg", 32'(seg), 32'h24);
        chk("f2_d2_an", 32'(an), 32'hB);
`ifdef COLON_BLINK_EN
        chk("f2_colon", 32'(dp), 32'h0);
`else
        chk("f2_colon", 32'(dp), 32'h1);
`endif
        at_edge(90);  chk("f2_d3_seg", 32'(seg), 32'h79);
        at_edge(98);  chk("f3_d0_seg", 32'(seg), 32'h10);
        at_edge(106); chk("f3_d1_seg", 32'(seg), 32'h12);
        at_edge(114); chk("f3_d2_seg", 32'(seg), 32'h30);
        at_edge(122); chk("f3_d3_seg", 32'(seg), 32'h24);

        // 3: 09:05, leading zero suppressed
        at_edge(130); set_time(4'd0, 4'd9, 4'd0, 4'd5);
        at_edge(146); chk("f4_colon", 32'(dp), 32'h1);
        at_edge(170); min_ones = 4'hC;
        at_edge(178); chk("f5_d2_seg", 32'(seg), 32'h10);
        at_edge(186); chk("f5_d3_an", 32'(an), 32'hF);

        // 5: invalid digit as dash, blank mid-slot and release
        at_edge(194); chk("dash_seg", 32'(seg), 32'h3F);
        at_edge(196); blank = 1'b1;
        at_edge(197); chk("blank_an", 32'(an), 32'hF);
        at_edge(205); blank = 1'b0;
        at_edge(206); chk("unblank_an", 32'(an), 32'hD);

        // Randomized phase; the model checks every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) blank = ~blank;
            if ($urandom_range(0, 9) == 0) begin
                hour_tens = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(0, 2));
                hour_ones = 4'($urandom_range(0, 10));
                min_tens  = 4'($urandom_range(0, 6));
                min_ones  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                        : 4'($urandom_range(0, 9));
            end
        end
        reset = 1'b0;
        blank = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
